// File: rtl/cpu_ctrl_pkg.sv
// +-----------------------------------------------------------------------------
// | cpu_ctrl_pkg : opcodes, FSM states and select encodings for the RV32 control path
// | Revision     : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_BR  = 2'b01;
   localparam logic [1:0] ALU_FN  = 2'b10;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;

   function automatic logic op_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: return 1'b1;
         default:                                          return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
// +-----------------------------------------------------------------------------
// | ctrl_wait_timer : counts handshake wait cycles; expired flags the last allowed one
// | Revision        : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module ctrl_wait_timer #(
   parameter int MAX_WAIT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clear,
   output logic expired
);

   localparam int CW = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);

   logic [CW-1:0] cnt_q;

   // A zero limit freezes the counter at 0 and never expires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (en && (MAX_WAIT != 0)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // cnt_q holds waits already completed, so MAX_WAIT-1 marks the final wait cycle
   assign expired = (MAX_WAIT != 0) && en && (cnt_q == CW'(MAX_WAIT - 1));

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// +-----------------------------------------------------------------------------
// | multicycle_ctrl_fsm : fetch/decode/exec/mem/wb sequencer for the multi-cycle RV32 core
// | Option              : PERF_CNT_EN adds cycle and retired-instruction counters
// | Revision            : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 0,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             br_taken,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic             alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic             halted,
   output logic             bus_err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   state_e     state_q, state_d;
   logic [6:0] opcode_q;
   logic       run_q;
   logic       bus_err_q, bus_err_d;
   logic       wait_en, wait_clear, wait_expired;
   logic       unused_instr;

   assign unused_instr = ^instr[31:7];

   logic is_r, is_i, is_ld, is_st, is_br, is_jal;
   assign is_r   = (opcode_q == OP_R);
   assign is_i   = (opcode_q == OP_I);
   assign is_ld  = (opcode_q == OP_LOAD);
   assign is_st  = (opcode_q == OP_STORE);
   assign is_br  = (opcode_q == OP_BRANCH);
   assign is_jal = (opcode_q == OP_JAL);

   // run_q keeps imem_req low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         opcode_q  <= '0;
         run_q     <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= 1'b1;
         bus_err_q <= bus_err_d;
         if (state_q == ST_DECODE) begin
            opcode_q <= instr[6:0];
         end
      end
   end

   assign wait_en    = run_q && (((state_q == ST_FETCH) && !imem_ready) ||
                                 ((state_q == ST_MEM)   && !dmem_ready));
   assign wait_clear = (state_d != state_q);

   ctrl_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (wait_en),
      .clear   (wait_clear),
      .expired (wait_expired)
   );

   always_comb begin
      state_d   = state_q;
      bus_err_d = bus_err_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      reg_we    = 1'b0;
      wb_sel    = WB_ALU;
      halted    = (state_q == ST_HALT);
      bus_err   = bus_err_q;

      case (state_q)
         ST_FETCH: begin
            if (run_q) begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we   = 1'b1;
                  state_d = ST_DECODE;
               end else if (wait_expired) begin
                  bus_err_d = 1'b1;
                  state_d   = ST_HALT;
               end
            end
         end
         ST_DECODE: begin
            state_d = op_legal(instr[6:0]) ? ST_EXEC : ST_HALT;
         end
         ST_EXEC: begin
            alu_src_b = !(is_r || is_br);
            alu_op    = is_br ? ALU_BR : ((is_r || is_i) ? ALU_FN : ALU_ADD);
            if (is_br) begin
               pc_we   = 1'b1;
               pc_src  = br_taken;
               state_d = ST_FETCH;
            end else if (is_ld || is_st) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_st;
            if (dmem_ready) begin
               if (is_st) begin
                  pc_we   = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (wait_expired) begin
               bus_err_d = 1'b1;
               state_d   = ST_HALT;
            end
         end
         ST_WB: begin
            reg_we  = 1'b1;
            pc_we   = 1'b1;
            state_d = ST_FETCH;
            if (is_jal) begin
               wb_sel = WB_PC4;
               pc_src = 1'b1;
            end else if (is_ld) begin
               wb_sel = WB_MEM;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cycle_q, instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (state_q != ST_HALT) begin
            cycle_q <= cycle_q + 1'b1;
         end
         if (pc_we) begin
            instret_q <= instret_q + 1'b1;
         end
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// +-----------------------------------------------------------------------------
// | tb_multicycle_ctrl_fsm : directed bench; dut_a has MAX_WAIT=4, dut_b unlimited waits
// | Revision               : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl_fsm;

`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // ctl = {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_src,alu_src_b,alu_op[1:0],reg_we,wb_sel[1:0],halted,bus_err}
   localparam logic [13:0] V_0   = 14'h0000;
   localparam logic [13:0] V_F   = 14'h2000;
   localparam logic [13:0] V_FR  = 14'h2400;
   localparam logic [13:0] V_D   = 14'h0000;
   localparam logic [13:0] V_EI  = 14'h00C0;
   localparam logic [13:0] V_ER  = 14'h0040;
   localparam logic [13:0] V_EM  = 14'h0080;
   localparam logic [13:0] V_EBT = 14'h0320;
   localparam logic [13:0] V_EBN = 14'h0220;
   localparam logic [13:0] V_M   = 14'h1000;
   localparam logic [13:0] V_MSR = 14'h1A00;
   localparam logic [13:0] V_WRI = 14'h0210;
   localparam logic [13:0] V_WL  = 14'h0214;
   localparam logic [13:0] V_WJ  = 14'h0318;
   localparam logic [13:0] V_H   = 14'h0002;
   localparam logic [13:0] V_HB  = 14'h0003;

   localparam logic [31:0] I_ADDI = 32'h0050_0093;
   localparam logic [31:0] I_LW   = 32'h0000_2083;
   localparam logic [31:0] I_SW   = 32'h0010_2023;
   localparam logic [31:0] I_BEQ  = 32'h0000_0063;
   localparam logic [31:0] I_JAL  = 32'h0000_006F;
   localparam logic [31:0] I_ADD  = 32'h0000_0033;
   localparam logic [31:0] I_ILL  = 32'h0000_007F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        imem_ready, dmem_ready, br_taken;

   logic        a_imem_req, a_dmem_req, a_dmem_we, a_ir_we, a_pc_we, a_pc_src, a_alu_src_b;
   logic [1:0]  a_alu_op, a_wb_sel;
   logic        a_reg_we, a_halted, a_bus_err;
   logic [31:0] a_cyc, a_ret;
   logic        b_imem_req, b_dmem_req, b_dmem_we, b_ir_we, b_pc_we, b_pc_src, b_alu_src_b;
   logic [1:0]  b_alu_op, b_wb_sel;
   logic        b_reg_we, b_halted, b_bus_err;
   logic [31:0] b_cyc, b_ret;
   logic [13:0] a_ctl, b_ctl;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.MAX_WAIT(4), .CNT_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .br_taken(br_taken), .imem_req(a_imem_req),
      .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .ir_we(a_ir_we), .pc_we(a_pc_we),
      .pc_src(a_pc_src), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .reg_we(a_reg_we),
      .wb_sel(a_wb_sel), .halted(a_halted), .bus_err(a_bus_err),
      .cycle_cnt(a_cyc), .instret_cnt(a_ret)
   );

   multicycle_ctrl_fsm #(.MAX_WAIT(0), .CNT_W(32)) dut_b (
      .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .br_taken(br_taken), .imem_req(b_imem_req),
      .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .ir_we(b_ir_we), .pc_we(b_pc_we),
      .pc_src(b_pc_src), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .reg_we(b_reg_we),
      .wb_sel(b_wb_sel), .halted(b_halted), .bus_err(b_bus_err),
      .cycle_cnt(b_cyc), .instret_cnt(b_ret)
   );

   assign a_ctl = {a_imem_req, a_dmem_req, a_dmem_we, a_ir_we, a_pc_we, a_pc_src, a_alu_src_b,
                   a_alu_op, a_reg_we, a_wb_sel, a_halted, a_bus_err};
   assign b_ctl = {b_imem_req, b_dmem_req, b_dmem_we, b_ir_we, b_pc_we, b_pc_src, b_alu_src_b,
                   b_alu_op, b_reg_we, b_wb_sel, b_halted, b_bus_err};

   // Entered and left at posedge+1 with both DUTs running in FETCH
   task automatic apply_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; instr = '0; imem_ready = 1'b1; dmem_ready = 1'b1; br_taken = 1'b0;
      #3;
      total++; if (a_ctl !== V_0) begin bad++; $display("FAIL reset_a ctl=%h exp=%h", a_ctl, V_0); end
      total++; if (b_ctl !== V_0) begin bad++; $display("FAIL reset_b ctl=%h exp=%h", b_ctl, V_0); end
      total++; if (a_cyc !== 32'd0 || a_ret !== 32'd0) begin
         bad++; $display("FAIL reset_cnt cyc=%0d ret=%0d exp=0/0", a_cyc, a_ret); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      total++; if (a_ctl !== V_0) begin bad++; $display("FAIL release_a ctl=%h exp=%h", a_ctl, V_0); end
      imem_ready = 1'b0;
      @(posedge clk); #1;
      total++; if (a_ctl !== V_F) begin bad++; $display("FAIL first_fetch_a ctl=%h exp=%h", a_ctl, V_F); end
      total++; if (b_ctl !== V_F) begin bad++; $display("FAIL first_fetch_b ctl=%h exp=%h", b_ctl, V_F); end
   endtask

   task automatic test_addi();
      logic [13:0] ev [4];
      ev = '{V_FR, V_D, V_EI, V_WRI};
      instr = I_ADDI; imem_ready = 1'b1; dmem_ready = 1'b1; br_taken = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         total++; if (a_ctl !== ev[c]) begin bad++; $display("FAIL addi_a c%0d ctl=%h exp=%h", c, a_ctl, ev[c]); end
         total++; if (b_ctl !== ev[c]) begin bad++; $display("FAIL addi_b c%0d ctl=%h exp=%h", c, b_ctl, ev[c]); end
         @(posedge clk); #1;
      end
      total++; if (a_ret !== (PERF ? 32'd1 : 32'd0)) begin
         bad++; $display("FAIL addi_instret got=%0d exp=%0d", a_ret, PERF ? 1 : 0); end
      total++; if (b_cyc !== (PERF ? 32'd5 : 32'd0)) begin
         bad++; $display("FAIL addi_cycles got=%0d exp=%0d", b_cyc, PERF ? 5 : 0); end
   endtask

   task automatic test_load_wait();
      logic [13:0] ev [8];
      bit          dr [8];
      ev = '{V_FR, V_D, V_EM, V_M, V_M, V_M, V_M, V_WL};
      dr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      instr = I_LW; imem_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         dmem_ready = dr[c];
         #1;
         total++; if (a_ctl !== ev[c]) begin bad++; $display("FAIL load_a c%0d ctl=%h exp=%h", c, a_ctl, ev[c]); end
         total++; if (b_ctl !== ev[c]) begin bad++; $display("FAIL load_b c%0d ctl=%h exp=%h", c, b_ctl, ev[c]); end
         @(posedge clk); #1;
      end
      dmem_ready = 1'b1;
      total++; if (a_ret !== (PERF ? 32'd2 : 32'd0)) begin
         bad++; $display("FAIL load_instret got=%0d exp=%0d", a_ret, PERF ? 2 : 0); end
   endtask

   task automatic test_branch();
      logic [13:0] ev [6];
      bit          bt [6];
      ev = '{V_FR, V_D, V_EBT, V_FR, V_D, V_EBN};
      bt = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      instr = I_BEQ; imem_ready = 1'b1; dmem_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         br_taken = bt[c];
         #1;
         total++; if (a_ctl !== ev[c]) begin bad++; $display("FAIL branch_a c%0d ctl=%h exp=%h", c, a_ctl, ev[c]); end
         total++; if (b_ctl !== ev[c]) begin bad++; $display("FAIL branch_b c%0d ctl=%h exp=%h", c, b_ctl, ev[c]); end
         @(posedge clk); #1;
      end
      br_taken = 1'b0;
      total++; if (b_ret !== (PERF ? 32'd4 : 32'd0)) begin
         bad++; $display("FAIL branch_instret got=%0d exp=%0d", b_ret, PERF ? 4 : 0); end
   endtask

   task automatic test_r_store_jal();
      logic [13:0] ev [12];
      logic [31:0] ins [12];
      ev  = '{V_FR, V_D, V_ER, V_WRI, V_FR, V_D, V_EM, V_MSR, V_FR, V_D, V_EM, V_WJ};
      ins = '{I_ADD, I_ADD, I_ADD, I_ADD, I_SW, I_SW, I_SW, I_SW, I_JAL, I_JAL, I_JAL, I_JAL};
      imem_ready = 1'b1; dmem_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         instr = ins[c];
         #1;
         total++; if (a_ctl !== ev[c]) begin bad++; $display("FAIL rsj_a c%0d ctl=%h exp=%h", c, a_ctl, ev[c]); end
         total++; if (b_ctl !== ev[c]) begin bad++; $display("FAIL rsj_b c%0d ctl=%h exp=%h", c, b_ctl, ev[c]); end
         @(posedge clk); #1;
      end
      total++; if (a_ret !== (PERF ? 32'd7 : 32'd0)) begin
         bad++; $display("FAIL rsj_instret got=%0d exp=%0d", a_ret, PERF ? 7 : 0); end
   endtask

   task automatic test_illegal();
      logic [13:0] ev [5];
      ev = '{V_FR, V_D, V_H, V_H, V_H};
      instr = I_ILL; imem_ready = 1'b1; dmem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         total++; if (a_ctl !== ev[c]) begin bad++; $display("FAIL illegal_a c%0d ctl=%h exp=%h", c, a_ctl, ev[c]); end
         total++; if (b_ctl !== ev[c]) begin bad++; $display("FAIL illegal_b c%0d ctl=%h exp=%h", c, b_ctl, ev[c]); end
         @(posedge clk); #1;
      end
      total++; if (a_cyc !== (PERF ? 32'd33 : 32'd0) || a_ret !== (PERF ? 32'd7 : 32'd0)) begin
         bad++; $display("FAIL halt_counters cyc=%0d ret=%0d exp=%0d/%0d", a_cyc, a_ret,
                         PERF ? 33 : 0, PERF ? 7 : 0); end
   endtask

   task automatic test_watchdog();
      logic [13:0] ev_a [6];
      logic [13:0] ev [7];
      bit          ir [7];
      ev_a = '{V_F, V_F, V_F, V_F, V_HB, V_HB};
      ev   = '{V_F, V_F, V_F, V_FR, V_D, V_EI, V_WRI};
      ir   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      instr = I_ADDI; imem_ready = 1'b0; dmem_ready = 1'b0;
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         #1;
         total++; if (a_ctl !== ev_a[c]) begin bad++; $display("FAIL wdog_expire_a c%0d ctl=%h exp=%h", c, a_ctl, ev_a[c]); end
         total++; if (b_ctl !== V_F) begin bad++; $display("FAIL wdog_unlimited_b c%0d ctl=%h exp=%h", c, b_ctl, V_F); end
         @(posedge clk); #1;
      end
      apply_reset();
      dmem_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         imem_ready = ir[c];
         #1;
         total++; if (a_ctl !== ev[c]) begin bad++; $display("FAIL wdog_ready_a c%0d ctl=%h exp=%h", c, a_ctl, ev[c]); end
         total++; if (b_ctl !== ev[c]) begin bad++; $display("FAIL wdog_ready_b c%0d ctl=%h exp=%h", c, b_ctl, ev[c]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_access();
      logic [13:0] ev [4];
      ev = '{V_FR, V_D, V_EM, V_M};
      instr = I_LW; imem_ready = 1'b1; dmem_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         total++; if (a_ctl !== ev[c]) begin bad++; $display("FAIL mid_a c%0d ctl=%h exp=%h", c, a_ctl, ev[c]); end
         if (c < 3) begin
            @(posedge clk); #1;
         end
      end
      #2;
      rst_n = 1'b0;
      dmem_ready = 1'b1;
      #1;
      total++; if (a_ctl !== V_0) begin bad++; $display("FAIL mid_rst_a ctl=%h exp=%h", a_ctl, V_0); end
      total++; if (b_ctl !== V_0) begin bad++; $display("FAIL mid_rst_b ctl=%h exp=%h", b_ctl, V_0); end
      total++; if (a_cyc !== 32'd0 || a_ret !== 32'd0 || b_cyc !== 32'd0 || b_ret !== 32'd0) begin
         bad++; $display("FAIL mid_rst_cnt a=%0d/%0d b=%0d/%0d exp=0", a_cyc, a_ret, b_cyc, b_ret); end
      @(posedge clk); #1;
      rst_n = 1'b1; imem_ready = 1'b0;
      #1;
      total++; if (a_ctl !== V_0) begin bad++; $display("FAIL mid_release_a ctl=%h exp=%h", a_ctl, V_0); end
      @(posedge clk); #1;
      total++; if (a_ctl !== V_F) begin bad++; $display("FAIL mid_refetch_a ctl=%h exp=%h", a_ctl, V_F); end
      total++; if (b_ctl !== V_F) begin bad++; $display("FAIL mid_refetch_b ctl=%h exp=%h", b_ctl, V_F); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load_wait();
      test_branch();
      test_r_store_jal();
      test_illegal();
      test_watchdog();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

`default_nettype wire
